// File: rtl/logic_pkg.sv
// Shared constants for the logic register pipeline: function-select encodings
// and the supported pipeline depth range.
package logic_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NAND = 3'd0,
        OP_NOR  = 3'd1,
        OP_OR   = 3'd2,
        OP_AND  = 3'd3,
        OP_XOR  = 3'd4,
        OP_OAI  = 3'd5,
        OP_ORN  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_stage.sv
// One pipeline slot: result data plus valid flag, frozen while the enable is low.
module logic_stage
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/logic_reg_pipe.sv
// Bitwise logic unit with a DEPTH-stage stallable result pipeline and a counter
// of results handed downstream.
module logic_reg_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("logic_reg_pipe: DEPTH outside supported range");
    end

    logic             stall_c;
    logic             adv_c;
    logic [WIDTH-1:0] result_c;
    logic             valid_q [DEPTH+1];
    logic [WIDTH-1:0] data_q  [DEPTH+1];

    // A full output slot that is not being taken freezes the whole pipe.
    assign stall_c  = out_valid & ~out_ready;
    assign adv_c    = ~stall_c;
    assign in_ready = adv_c;

    always_comb begin
        result_c = in_a;
        case (op_e'(op))
            OP_NAND: result_c = ~(in_a & in_b);
            OP_NOR:  result_c = ~(in_a | in_b);
            OP_OR:   result_c = in_a | in_b;
            OP_AND:  result_c = in_a & in_b;
            OP_XOR:  result_c = in_a ^ in_b;
            OP_OAI:  result_c = ~(~(in_a | in_b) & in_c);
            OP_ORN:  result_c = ~in_a | in_b | in_c;
            OP_PASS: result_c = in_a;
        endcase
    end

    assign valid_q[0] = in_valid;
    assign data_q[0]  = result_c;

    // Every slot shifts together, so empty slots travel as bubbles.
    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        logic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv_c),
            .d_valid (valid_q[i-1]),
            .d_data  (data_q[i-1]),
            .q_valid (valid_q[i]),
            .q_data  (data_q[i])
        );
    end

    assign out       = data_q[DEPTH];
    assign out_valid = valid_q[DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_valid && out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_reg_pipe.sv
// Scoreboard bench for logic_reg_pipe: three instances (DEPTH 2/3/1) driven with
// directed vectors; a negedge monitor pops expected results as they are consumed.
module tb_logic_reg_pipe;

    typedef struct {
        logic [7:0] data;
        int         acc;
        bit         lat;
    } exp_t;

    logic        clk;
    logic        rst       [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  in_a      [3];
    logic [7:0]  in_b      [3];
    logic [7:0]  in_c      [3];
    logic [2:0]  op        [3];
    logic [7:0]  out_d     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    bit         ov_hist   [3][2048];
    bit         held_v    [3];
    logic [7:0] held      [3];
    int         stall_cnt [3];

    logic [2:0] vop  [16];
    logic [7:0] va   [16];
    logic [7:0] vb   [16];
    logic [7:0] vc   [16];
    logic [7:0] vexp [16];

    logic_reg_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) u_dut_d2 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_c(in_c[0]), .op(op[0]),
        .out(out_d[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .cnt(cnt0)
    );

    logic_reg_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_dut_d3 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_c(in_c[1]), .op(op[1]),
        .out(out_d[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .cnt(cnt1)
    );

    logic_reg_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(16)) u_dut_d1 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_c(in_c[2]), .op(op[2]),
        .out(out_d[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1);
    end

    function automatic int dep(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        ncmp++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: consumes results, checks order, latency, hold-while-stalled.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                held_v[d] = 1'b0;
            end else begin
                if (cyc < 2048) ov_hist[d][cyc] = out_valid[d];
                if (held_v[d] && out_valid[d])
                    chk($sformatf("d%0d out held during stall", d), 32'(out_d[d]), 32'(held[d]));
                if (out_valid[d] && !out_ready[d]) begin
                    stall_cnt[d]++;
                    chk($sformatf("d%0d in_ready during stall", d), 32'(in_ready[d]), 32'd0);
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (qsize(d) == 0) begin
                        chk($sformatf("d%0d unexpected result", d), 32'(out_valid[d]), 32'd0);
                    end else begin
                        exp_t e;
                        e = qpop(d);
                        chk($sformatf("d%0d result data", d), 32'(out_d[d]), 32'(e.data));
                        if (e.lat)
                            chk($sformatf("d%0d latency", d), 32'(cyc - e.acc), 32'(dep(d)));
                    end
                end
                held_v[d] = out_valid[d] && !out_ready[d];
                held[d]   = out_d[d];
            end
        end
    end

    task automatic send(input int d, input int k, input bit lat, output int acc);
        bit   ok;
        exp_t e;
        ok  = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        in_a[d] = va[k];
        in_b[d] = vb[k];
        in_c[d] = vc[k];
        op[d]   = vop[k];
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[d]) ok = 1'b1;
        end
        if (ok) begin
            e.data = vexp[k];
            e.acc  = cyc;
            e.lat  = lat;
            push(d, e);
            acc = cyc;
        end else begin
            chk($sformatf("d%0d accept timeout", d), 32'(in_ready[d]), 32'd1);
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_a[d]     = 8'hEE;
        in_b[d]     = 8'h11;
    endtask

    task automatic drain(input int d);
        for (int t = 0; t < 100 && qsize(d) != 0; t++) begin
            @(negedge clk); #1;
        end
        if (qsize(d) != 0)
            chk($sformatf("d%0d drain timeout, pending", d), 32'(qsize(d)), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int a0;
        int nb;
        bit seen;

        vop[0]  = 3'd0; vop[1]  = 3'd1; vop[2]  = 3'd2; vop[3]  = 3'd3;
        vop[4]  = 3'd4; vop[5]  = 3'd5; vop[6]  = 3'd6; vop[7]  = 3'd7;
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'hC3; vb[i] = 8'h5A; vc[i] = 8'h0F;
            vop[i+8] = vop[i];
            va[i+8] = 8'hF0; vb[i+8] = 8'hCC; vc[i+8] = 8'hAA;
        end
        vexp[0]  = 8'hBD; vexp[1]  = 8'h24; vexp[2]  = 8'hDB; vexp[3]  = 8'h42;
        vexp[4]  = 8'h99; vexp[5]  = 8'hFB; vexp[6]  = 8'h7F; vexp[7]  = 8'hC3;
        vexp[8]  = 8'h3F; vexp[9]  = 8'h03; vexp[10] = 8'hFC; vexp[11] = 8'hC0;
        vexp[12] = 8'h3C; vexp[13] = 8'hFD; vexp[14] = 8'hEF; vexp[15] = 8'hF0;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            in_a[d] = '0; in_b[d] = '0; in_c[d] = '0; op[d] = '0;
            held_v[d] = 1'b0; stall_cnt[d] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset out_valid", d), 32'(out_valid[d]), 32'd0);
            chk($sformatf("d%0d reset out", d), 32'(out_d[d]), 32'd0);
            chk($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 32'd1);
        end
        chk("d0 reset cnt", 32'(cnt0), 32'd0);
        chk("d1 reset cnt", 32'(cnt1), 32'd0);
        chk("d2 reset cnt", 32'(cnt2), 32'd0);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Function sweep on the DEPTH=2 instance.
        for (int k = 0; k < 16; k += 1) begin
            if (k < 8) send(0, k, 1'b1, acc);
        end
        idle(0);
        drain(0);
        chk("d0 cnt after sweep", 32'(cnt0), 32'd8);

        // Bubble pattern 1,0,1.
        send(0, 8, 1'b1, nb);
        idle(0);
        send(0, 12, 1'b1, acc);
        idle(0);
        drain(0);
        chk("d0 bubble ov[0]", 32'(ov_hist[0][nb+2]), 32'd1);
        chk("d0 bubble ov[1]", 32'(ov_hist[0][nb+3]), 32'd0);
        chk("d0 bubble ov[2]", 32'(ov_hist[0][nb+4]), 32'd1);
        chk("d0 cnt after bubbles", 32'(cnt0), 32'd10);

        // 4-bit counter wrap: 15, then 0, then 1.
        for (int k = 9; k < 14; k++) send(0, k, 1'b1, acc);
        idle(0);
        drain(0);
        chk("d0 cnt at 15", 32'(cnt0), 32'd15);
        send(0, 14, 1'b1, acc);
        idle(0);
        drain(0);
        chk("d0 cnt wrap to 0", 32'(cnt0), 32'd0);
        send(0, 15, 1'b1, acc);
        idle(0);
        drain(0);
        chk("d0 cnt after wrap", 32'(cnt0), 32'd1);

        // Asynchronous reset with two results in flight.
        send(0, 0, 1'b1, acc);
        send(0, 4, 1'b1, acc);
        @(posedge clk);
        #2;
        rst[0] = 1'b1;
        in_valid[0] = 1'b0;
        #1;
        chk("d0 mid-reset out_valid", 32'(out_valid[0]), 32'd0);
        chk("d0 mid-reset out", 32'(out_d[0]), 32'd0);
        chk("d0 mid-reset cnt", 32'(cnt0), 32'd0);
        chk("d0 mid-reset in_ready", 32'(in_ready[0]), 32'd1);
        q0.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("d0 no result after reset", 32'(out_valid[0]), 32'd0);
        end
        send(0, 6, 1'b1, acc);
        idle(0);
        drain(0);
        chk("d0 cnt after reset", 32'(cnt0), 32'd1);

        // Stall on the DEPTH=3 instance.
        fork
            begin
                for (int k = 0; k < 5; k++) send(1, k, 1'b0, acc);
                idle(1);
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(posedge clk); #1;
                    if (out_valid[1]) seen = 1'b1;
                end
                chk("d1 first out_valid seen", 32'(seen), 32'd1);
                out_ready[1] = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready[1] = 1'b1;
            end
        join
        drain(1);
        chk("d1 stall cycles", 32'(stall_cnt[1]), 32'd4);
        chk("d1 cnt after stall", 32'(cnt1), 32'd5);

        // DEPTH=1 back-to-back throughput.
        send(2, 0, 1'b1, a0);
        for (int i = 1; i < 10; i++) send(2, (i * 3) % 16, 1'b1, acc);
        idle(2);
        drain(2);
        @(negedge clk); #1;
        for (int i = 1; i <= 10; i++)
            chk($sformatf("d2 throughput ov[%0d]", i), 32'(ov_hist[2][a0+i]), 32'd1);
        chk("d2 throughput ov after", 32'(ov_hist[2][a0+11]), 32'd0);
        chk("d2 cnt", 32'(cnt2), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
